// File: rtl/aes_shift_rows_pipe_if.sv
// Valid/ready block interface for the ShiftRows pipeline stage.
// master = upstream/downstream environment, slave = the stage itself.
interface aes_shift_rows_pipe_if #(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned STATE_W = 32 * NB;

  logic               in_valid;
  logic               in_ready;
  logic               in_inv;
  logic [TAG_W-1:0]   in_tag;
  logic [STATE_W-1:0] in_state;
  logic               out_valid;
  logic               out_ready;
  logic [TAG_W-1:0]   out_tag;
  logic [STATE_W-1:0] out_state;

  modport master (
    output in_valid, in_inv, in_tag, in_state, out_ready,
    input  in_ready, out_valid, out_tag, out_state
  );

  modport slave (
    input  in_valid, in_inv, in_tag, in_state, out_ready,
    output in_ready, out_valid, out_tag, out_state
  );
endinterface

// File: rtl/aes_shift_rows_pipe.sv
// Registered Rijndael ShiftRows/InvShiftRows stage (Nb = 4/6/8) with
// per-block direction select, sideband tag and valid/ready flow control.
module aes_shift_rows_pipe #(
  parameter int unsigned NB     = 4,
  parameter int unsigned REG_IN = 0,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  aes_shift_rows_pipe_if.slave bus
);
  localparam int unsigned STATE_W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shift_rows_pipe: TAG_W must be at least 1");
  end

  logic               out_valid_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic [STATE_W-1:0] out_state_q;
  logic               out_free_c;
  logic               in_ready_c;
  logic               feed_valid_c;
  logic               feed_inv_c;
  logic [TAG_W-1:0]   feed_tag_c;
  logic [STATE_W-1:0] feed_state_c;
  logic [STATE_W-1:0] fwd_c;
  logic [STATE_W-1:0] inv_c;
  logic [STATE_W-1:0] perm_c;

  assign out_free_c = !out_valid_q || bus.out_ready;

  if (REG_IN != 0) begin : g_reg_in
    logic               s0_valid_q;
    logic               s0_inv_q;
    logic [TAG_W-1:0]   s0_tag_q;
    logic [STATE_W-1:0] s0_state_q;
    logic               s0_ready_c;

    assign s0_ready_c = !s0_valid_q || out_free_c;
    assign in_ready_c = s0_ready_c && !flush;

    // Input register; flush wins over any load offered in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s0_valid_q <= 1'b0;
        s0_inv_q   <= 1'b0;
        s0_tag_q   <= '0;
        s0_state_q <= '0;
      end else if (flush) begin
        s0_valid_q <= 1'b0;
      end else if (s0_ready_c) begin
        s0_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s0_inv_q   <= bus.in_inv;
          s0_tag_q   <= bus.in_tag;
          s0_state_q <= bus.in_state;
        end
      end
    end

    assign feed_valid_c = s0_valid_q;
    assign feed_inv_c   = s0_inv_q;
    assign feed_tag_c   = s0_tag_q;
    assign feed_state_c = s0_state_q;
  end else begin : g_no_reg_in
    assign in_ready_c   = out_free_c && !flush;
    assign feed_valid_c = bus.in_valid;
    assign feed_inv_c   = bus.in_inv;
    assign feed_tag_c   = bus.in_tag;
    assign feed_state_c = bus.in_state;
  end

  // Byte routing: byte k sits at row k%4, column k/4, byte 0 at the MSBs.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int unsigned OFF = (NB == 8 && r >= 2) ? r + 1 : r;
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int unsigned DST   = r + 4 * c;
      localparam int unsigned SRC_F = r + 4 * ((c + OFF) % NB);
      localparam int unsigned SRC_I = r + 4 * ((c + NB - OFF) % NB);
      assign fwd_c[STATE_W-1-8*DST -: 8] = feed_state_c[STATE_W-1-8*SRC_F -: 8];
      assign inv_c[STATE_W-1-8*DST -: 8] = feed_state_c[STATE_W-1-8*SRC_I -: 8];
    end
  end

  assign perm_c = feed_inv_c ? inv_c : fwd_c;

  // Output register; holds while stalled, reloads on simultaneous pop/push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_state_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free_c) begin
      out_valid_q <= feed_valid_c;
      if (feed_valid_c) begin
        out_tag_q   <= feed_tag_c;
        out_state_q <= perm_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_state = out_state_q;
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed/table-driven bench for aes_shift_rows_pipe: NB=4 (REG_IN=0),
// NB=6 (REG_IN=0) and NB=8 (REG_IN=1) instances with a queue scoreboard.
module tb_aes_shift_rows_pipe;
  localparam int unsigned TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush4, flush6, flush8;

  always #5 clk = ~clk;

  aes_shift_rows_pipe_if #(.NB(4), .TAG_W(TAG_W)) b4 ();
  aes_shift_rows_pipe_if #(.NB(6), .TAG_W(TAG_W)) b6 ();
  aes_shift_rows_pipe_if #(.NB(8), .TAG_W(TAG_W)) b8 ();

  aes_shift_rows_pipe #(.NB(4), .REG_IN(0), .TAG_W(TAG_W)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .bus(b4));
  aes_shift_rows_pipe #(.NB(6), .REG_IN(0), .TAG_W(TAG_W)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush6), .bus(b6));
  aes_shift_rows_pipe #(.NB(8), .REG_IN(1), .TAG_W(TAG_W)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .bus(b8));

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference model, written directly from the row-offset definition.
  function automatic logic [255:0] ref_shift(input logic [255:0] s, input logic inv, input int nb);
    logic [255:0] o;
    int off, src, top;
    o = '0;
    top = 32 * nb - 1;
    for (int r = 0; r < 4; r++) begin
      off = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - off + nb) % nb : (c + off) % nb;
        o[top - 8*(r + 4*c) -: 8] = s[top - 8*(r + 4*src) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  typedef struct { logic [255:0] st; logic [TAG_W-1:0] tg; } exp_t;
  exp_t q6[$];
  exp_t q8[$];

  // Scoreboards: sample mid-cycle, after the negedge drive has settled.
  always @(negedge clk) begin : mon6
    exp_t e;
    #1;
    if (!rst_n || flush6) q6.delete();
    else begin
      if (b6.out_valid && b6.out_ready) begin
        if (q6.size() == 0) begin
          checks++; errors++;
          $display("FAIL d6_unexpected_out: got %h expected no block", b6.out_state);
        end else begin
          e = q6.pop_front();
          check("d6_state", 256'(b6.out_state), e.st);
          check("d6_tag", 256'(b6.out_tag), 256'(e.tg));
        end
      end
      if (b6.in_valid && b6.in_ready)
        q6.push_back('{ref_shift(256'(b6.in_state), b6.in_inv, 6), b6.in_tag});
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    #1;
    if (!rst_n || flush8) q8.delete();
    else begin
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL d8_unexpected_out: got %h expected no block", b8.out_state);
        end else begin
          e = q8.pop_front();
          check("d8_state", b8.out_state, e.st);
          check("d8_tag", 256'(b8.out_tag), 256'(e.tg));
        end
      end
      if (b8.in_valid && b8.in_ready)
        q8.push_back('{ref_shift(b8.in_state, b8.in_inv, 8), b8.in_tag});
    end
  end

  // Handshake-aware drivers: a new block is offered only once the last one was taken.
  logic rdy6 = 1'b0, rdy8 = 1'b0, alt6 = 1'b0, alt8 = 1'b0;
  logic [TAG_W-1:0] tag6 = '0, tag8 = '0;
  int acc8 = 0;

  task automatic cyc6(input bit v, input bit ordy);
    @(negedge clk);
    if (!b6.in_valid || rdy6) begin
      b6.in_state = 192'(rand256());
      b6.in_inv   = alt6;
      alt6        = ~alt6;
      b6.in_tag   = tag6;
      tag6        = tag6 + TAG_W'(1);
    end
    b6.in_valid  = v;
    b6.out_ready = ordy;
    #1 rdy6 = b6.in_ready;
  endtask

  task automatic cyc8(input bit v, input bit ordy, input bit fl);
    @(negedge clk);
    if (b8.in_valid && rdy8) acc8++;
    if (!b8.in_valid || rdy8) begin
      b8.in_state = rand256();
      b8.in_inv   = alt8;
      alt8        = ~alt8;
      b8.in_tag   = tag8;
      tag8        = tag8 + TAG_W'(1);
    end
    b8.in_valid  = v;
    b8.out_ready = ordy;
    flush8       = fl;
    #1 rdy8 = b8.in_ready;
  endtask

  task automatic drain8();
    for (int k = 0; k < 50; k++) begin
      #1;
      if (q8.size() == 0 && !b8.out_valid) break;
      cyc8(0, 1, 0);
    end
    check("d8_drain_queue", 256'(q8.size()), 256'(0));
    check("d8_drain_valid", 256'(b8.out_valid), 256'(0));
  endtask

  task automatic drain6();
    for (int k = 0; k < 50; k++) begin
      #1;
      if (q6.size() == 0 && !b6.out_valid) break;
      cyc6(0, 1);
    end
    check("d6_drain_queue", 256'(q6.size()), 256'(0));
    check("d6_drain_valid", 256'(b6.out_valid), 256'(0));
  endtask

  typedef struct {
    logic             inv;
    logic [TAG_W-1:0] tag;
    logic [127:0]     st;
    logic [127:0]     expv;
  } vec_t;
  localparam int NV = 5;
  vec_t vt[NV];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] x, y, hold_st;
    logic [TAG_W-1:0] hold_tg;
    int a0;

    vt[0] = '{1'b0, 4'h3, 128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};
    vt[1] = '{1'b1, 4'h5, 128'h00050a0f04090e03080d02070c01060b, 128'h000102030405060708090a0b0c0d0e0f};
    vt[2] = '{1'b0, 4'h9, 128'h00112233445566778899aabbccddeeff, 128'h0055aaff4499ee3388dd2277cc1166bb};
    vt[3] = '{1'b1, 4'h0, 128'h000102030405060708090a0b0c0d0e0f, 128'h000d0a0704010e0b0805020f0c090603};
    vt[4] = '{1'b1, 4'hf, {128{1'b1}}, {128{1'b1}}};

    rst_n = 1'b0; flush4 = 1'b0; flush6 = 1'b0; flush8 = 1'b0;
    b4.in_valid = 1'b0; b4.in_inv = 1'b0; b4.in_tag = '0; b4.in_state = '0; b4.out_ready = 1'b1;
    b6.in_valid = 1'b0; b6.in_inv = 1'b0; b6.in_tag = '0; b6.in_state = '0; b6.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_inv = 1'b0; b8.in_tag = '0; b8.in_state = '0; b8.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_d4_out_valid", 256'(b4.out_valid), 256'(0));
    check("rst_d4_out_state", 256'(b4.out_state), 256'(0));
    check("rst_d4_out_tag", 256'(b4.out_tag), 256'(0));
    check("rst_d4_in_ready", 256'(b4.in_ready), 256'(1));
    check("rst_d8_out_valid", 256'(b8.out_valid), 256'(0));
    check("rst_d8_in_ready", 256'(b8.in_ready), 256'(1));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_d4_in_ready", 256'(b4.in_ready), 256'(1));

    // Table vectors on NB=4, back to back with mixed directions
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("vec%0d_valid", i-1), 256'(b4.out_valid), 256'(1));
        check($sformatf("vec%0d_state", i-1), 256'(b4.out_state), 256'(vt[i-1].expv));
        check($sformatf("vec%0d_tag", i-1), 256'(b4.out_tag), 256'(vt[i-1].tag));
      end
      check($sformatf("vec%0d_in_ready", i), 256'(b4.in_ready), 256'(1));
      if (i < NV) begin
        b4.in_valid = 1'b1; b4.in_inv = vt[i].inv; b4.in_tag = vt[i].tag; b4.in_state = vt[i].st;
      end else begin
        b4.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("d4_idle_valid", 256'(b4.out_valid), 256'(0));

    // Forward then inverse returns the original block
    for (int i = 0; i < 32; i++) begin
      x = 128'(rand256());
      b4.in_valid = 1'b1; b4.in_inv = 1'b0; b4.in_tag = TAG_W'(i); b4.in_state = x;
      @(negedge clk);
      check("rt_fwd", 256'(b4.out_state), ref_shift(256'(x), 1'b0, 4));
      y = b4.out_state;
      b4.in_inv = 1'b1; b4.in_state = y;
      @(negedge clk);
      check("rt_identity", 256'(b4.out_state), 256'(x));
    end
    b4.in_valid = 1'b0;

    // NB=6 stream, alternating direction, random backpressure
    for (int i = 0; i < 40; i++) cyc6(1, $urandom_range(0, 3) != 0);
    drain6();

    // NB=8 / REG_IN=1 stream at full rate: one acceptance per cycle
    a0 = acc8;
    for (int i = 0; i < 30; i++) cyc8(1, 1, 0);
    drain8();
    check("d8_throughput", 256'(acc8 - a0), 256'(30));

    // Stall with REG_IN=1: exactly two blocks fit, outputs hold
    a0 = acc8;
    cyc8(1, 0, 0);
    cyc8(1, 0, 0);
    cyc8(1, 0, 0);
    check("stall_in_ready", 256'(rdy8), 256'(0));
    check("stall_out_valid", 256'(b8.out_valid), 256'(1));
    hold_st = 128'(b8.out_state);
    hold_tg = b8.out_tag;
    for (int i = 0; i < 2; i++) begin
      cyc8(1, 0, 0);
      check("stall_hold_ready", 256'(rdy8), 256'(0));
      check("stall_hold_valid", 256'(b8.out_valid), 256'(1));
      check("stall_hold_state", 256'(b8.out_state[127:0]), 256'(hold_st));
      check("stall_hold_tag", 256'(b8.out_tag), 256'(hold_tg));
    end
    check("stall_accepted", 256'(acc8 - a0), 256'(2));
    for (int i = 0; i < 6; i++) cyc8(1, 1, 0);
    drain8();

    // Flush with two blocks in flight and a third offered
    cyc8(1, 0, 0);
    cyc8(1, 0, 0);
    cyc8(1, 0, 1);
    check("flush_in_ready", 256'(rdy8), 256'(0));
    cyc8(0, 0, 0);
    check("flush_out_valid", 256'(b8.out_valid), 256'(0));
    for (int i = 0; i < 3; i++) begin
      cyc8(0, 1, 0);
      check("flush_stays_empty", 256'(b8.out_valid), 256'(0));
    end
    cyc8(1, 1, 0);
    cyc8(0, 1, 0);
    check("lat2_early", 256'(b8.out_valid), 256'(0));
    cyc8(0, 1, 0);
    check("lat2_valid", 256'(b8.out_valid), 256'(1));
    drain8();

    // Asynchronous reset between clock edges, mid-stream
    @(negedge clk);
    b4.in_valid = 1'b1; b4.in_inv = vt[2].inv; b4.in_tag = vt[2].tag; b4.in_state = vt[2].st;
    @(posedge clk);
    #3;
    check("pre_arst_valid", 256'(b4.out_valid), 256'(1));
    rst_n = 1'b0;
    b4.in_valid = 1'b0;
    #1;
    check("arst_out_valid", 256'(b4.out_valid), 256'(0));
    check("arst_out_state", 256'(b4.out_state), 256'(0));
    check("arst_in_ready", 256'(b4.in_ready), 256'(1));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("arst_discarded", 256'(b4.out_valid), 256'(0));
    check("arst_release_ready", 256'(b4.in_ready), 256'(1));
    b4.in_valid = 1'b1; b4.in_inv = vt[0].inv; b4.in_tag = vt[0].tag; b4.in_state = vt[0].st;
    @(negedge clk);
    b4.in_valid = 1'b0;
    check("arst_fresh_valid", 256'(b4.out_valid), 256'(1));
    check("arst_fresh_state", 256'(b4.out_state), 256'(vt[0].expv));
    check("arst_fresh_tag", 256'(b4.out_tag), 256'(vt[0].tag));
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
